mult_seq8: RTL and testbench

Sequencer and register file for the 8-bit signed shift-add multiplier. It holds the X/A/B product registers and the latched multiplicand, drives operands and the add/subtract select into the external 9-bit adder/subtractor, and writes the adder's 9-bit sum back into X/A. It then arithmetically shifts {X,A,B}, producing the signed 16-bit product {A,B} after 8 iterations.

---
 rtl/mult_seq8.sv | 115 +++++++++++
 tb/tb_mult_seq8.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mult_seq8.sv
// rtl/mult_seq8.sv - sequencer and X/A/B register file for an 8-bit signed shift-add multiplier
// Optional build macro MULT_SKIP_ZERO_EN: skip the ADD state when the current multiplier bit is 0.
module mult_seq8 (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       ClearA_LoadB,
    input  logic [7:0] S,
    input  logic [8:0] add_sum,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    output logic       add_fn,
    output logic [7:0] Aval,
    output logic [7:0] Bval,
    output logic       Xval,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state, state_n;
    logic       x, x_n;
    logic [7:0] a, a_n;
    logic [7:0] b, b_n;
    logic [7:0] m, m_n;
    logic [2:0] cnt, cnt_n;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            x     <= 1'b0;
            a     <= 8'h00;
            b     <= 8'h00;
            m     <= 8'h00;
            cnt   <= 3'd0;
        end else begin
            state <= state_n;
            x     <= x_n;
            a     <= a_n;
            b     <= b_n;
            m     <= m_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        x_n     = x;
        a_n     = a;
        b_n     = b;
        m_n     = m;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                // Load wins over start; B is deliberately not reloaded on start.
                if (ClearA_LoadB) begin
                    x_n = 1'b0;
                    a_n = 8'h00;
                    b_n = S;
                end else if (Run) begin
                    x_n   = 1'b0;
                    a_n   = 8'h00;
                    m_n   = S;
                    cnt_n = 3'd0;
`ifdef MULT_SKIP_ZERO_EN
                    state_n = b[0] ? ADD : SHIFT;
`else
                    state_n = ADD;
`endif
                end
            end
            ADD: begin
                if (b[0]) begin
                    a_n = add_sum[7:0];
                    x_n = add_sum[8];
                end
                state_n = SHIFT;
            end
            SHIFT: begin
                a_n = {x, a[7:1]};
                b_n = {a[0], b[7:1]};
                if (cnt == 3'd7) begin
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + 3'd1;
`ifdef MULT_SKIP_ZERO_EN
                    // b[1] becomes the next multiplier bit after this shift.
                    state_n = b[1] ? ADD : SHIFT;
`else
                    state_n = ADD;
`endif
                end
            end
            DONE: begin
                if (!Run) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // The last multiplier bit carries negative weight, hence the subtract.
    assign add_fn = (state == ADD) && (cnt == 3'd7);
    assign add_a  = a;
    assign add_b  = m;
    assign Aval   = a;
    assign Bval   = b;
    assign Xval   = x;
    assign done   = (state == DONE);

endmodule

// File: tb/tb_mult_seq8.sv
// tb/tb_mult_seq8.sv - directed vector bench for mult_seq8 with a behavioral 9-bit adder/subtractor
module tb_mult_seq8;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Run;
    logic       ClearA_LoadB;
    logic [7:0] S;
    logic [8:0] add_sum;
    logic [7:0] add_a, add_b, Aval, Bval;
    logic       add_fn, Xval, done;

    int n_checks = 0;
    int n_fail   = 0;

    mult_seq8 dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .S            (S),
        .add_sum      (add_sum),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_fn       (add_fn),
        .Aval         (Aval),
        .Bval         (Bval),
        .Xval         (Xval),
        .done         (done)
    );

    always #5 Clk = ~Clk;

    // External sign-extending adder/subtractor.
    always_comb begin
        add_sum = 9'h000;
        if (add_fn) add_sum = {add_a[7], add_a} - {add_b[7], add_b};
        else        add_sum = {add_a[7], add_a} + {add_b[7], add_b};
    end

    typedef struct {
        logic       load;
        logic [7:0] b;
        logic [7:0] s;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic       exp_x;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_b(input logic [7:0] v);
        ClearA_LoadB = 1'b1;
        S = v;
        @(posedge Clk);
        @(negedge Clk);
        ClearA_LoadB = 1'b0;
    endtask

    // Edge count includes the start edge; S is scrambled after start to prove M is latched.
    task automatic run_mult(input logic [7:0] s, output int edges, output int fn_cnt, output int fn_edge);
        edges = 0;
        fn_cnt = 0;
        fn_edge = -1;
        Run = 1'b1;
        S = s;
        @(posedge Clk);
        edges = 1;
        @(negedge Clk);
        S = ~s;
        while (!done && edges < 40) begin
            if (add_fn) begin
                fn_cnt++;
                fn_edge = edges;
            end
            @(posedge Clk);
            edges++;
            @(negedge Clk);
        end
    endtask

    initial begin
        logic [7:0] b_model;
        logic [7:0] a_hold;
        int edges, fn_cnt, fn_edge, exp_edges, exp_fn;

        vecs[0] = '{1'b1, 8'h07, 8'h3B, 8'h01, 8'h9D, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 8'h02, 8'hFF, 8'h3A, 1'b1};
        vecs[2] = '{1'b1, 8'hF9, 8'h3B, 8'hFE, 8'h63, 1'b1};
        vecs[3] = '{1'b1, 8'h80, 8'h80, 8'h40, 8'h00, 1'b0};
        vecs[4] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 8'h01, 1'b0};
        vecs[5] = '{1'b1, 8'h7F, 8'h80, 8'hC0, 8'h80, 1'b1};
        vecs[6] = '{1'b1, 8'h00, 8'h55, 8'h00, 8'h00, 1'b0};
        vecs[7] = '{1'b1, 8'h80, 8'h7F, 8'hC0, 8'h80, 1'b1};

        Reset = 1'b1;
        Run = 1'b0;
        ClearA_LoadB = 1'b0;
        S = 8'h00;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        check("reset_a", Aval, 8'h00);
        check("reset_b", Bval, 8'h00);
        check("reset_x", Xval, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_m", add_b, 8'h00);
        check("reset_fn", add_fn, 1'b0);

        b_model = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].load) begin
                load_b(vecs[i].b);
                b_model = vecs[i].b;
                check($sformatf("v%0d_loadb", i), Bval, b_model);
            end
`ifdef MULT_SKIP_ZERO_EN
            exp_edges = 9 + $countones(b_model);
            exp_fn = b_model[7] ? 1 : 0;
`else
            exp_edges = 17;
            exp_fn = 1;
`endif
            run_mult(vecs[i].s, edges, fn_cnt, fn_edge);
            check($sformatf("v%0d_edges", i), edges, exp_edges);
            check($sformatf("v%0d_a", i), Aval, vecs[i].exp_a);
            check($sformatf("v%0d_b", i), Bval, vecs[i].exp_b);
            check($sformatf("v%0d_x", i), Xval, vecs[i].exp_x);
            check($sformatf("v%0d_fn_count", i), fn_cnt, exp_fn);
`ifndef MULT_SKIP_ZERO_EN
            check($sformatf("v%0d_fn_edge", i), fn_edge, 15);
`endif
            a_hold = Aval;
            repeat (3) @(posedge Clk);
            @(negedge Clk);
            check($sformatf("v%0d_hold_done", i), done, 1'b1);
            check($sformatf("v%0d_hold_a", i), Aval, a_hold);
            Run = 1'b0;
            @(posedge Clk);
            @(negedge Clk);
            check($sformatf("v%0d_idle", i), done, 1'b0);
            b_model = vecs[i].exp_b;
        end

        // Reset in the middle of a multiply.
        load_b(8'h07);
        Run = 1'b1;
        S = 8'h3B;
        repeat (6) @(posedge Clk);
        @(negedge Clk);
        Run = 1'b0;
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        check("midreset_a", Aval, 8'h00);
        check("midreset_b", Bval, 8'h00);
        check("midreset_x", Xval, 1'b0);
        check("midreset_m", add_b, 8'h00);
        repeat (20) @(posedge Clk);
        @(negedge Clk);
        check("midreset_idle", done, 1'b0);
        check("midreset_b_stable", Bval, 8'h00);

        // Load has priority over start.
        ClearA_LoadB = 1'b1;
        Run = 1'b1;
        S = 8'h5A;
        @(posedge Clk);
        @(negedge Clk);
        ClearA_LoadB = 1'b0;
        Run = 1'b0;
        check("prio_b", Bval, 8'h5A);
        check("prio_a", Aval, 8'h00);
        repeat (20) @(posedge Clk);
        @(negedge Clk);
        check("prio_no_start_done", done, 1'b0);
        check("prio_no_start_b", Bval, 8'h5A);
        check("prio_no_start_m", add_b, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
